// File: rtl/aes_pkg.sv
// Shared AES sequencing definitions: block/word widths, round-count helper, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_WORD_W  = 32;
    localparam int RK_IDX_W    = 4;

    // Controller states. ROUND/FINAL drive the external datapaths.
    // DONE holds the ciphertext until it is taken.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // Round count for a key length given in 32-bit words.
    function automatic int NR_FOR_NK(input int nk);
        case (nk)
            6:       return 12;
            8:       return 14;
            default: return 10;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES-encrypt sequencer around an external full-round and final-round datapath.
// Latency: accept in cycle T -> out_valid in cycle T+Nr+1; one block per Nr+2 cycles at full rate.
// Backpressure: out_ready low holds DONE with out_data frozen; in_ready is high only in IDLE.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    plaintext handshake, in_data = 128-bit block (byte 0 in [127:120])
//   rk_idx -> rk_data    round-key lookup; the key store answers in the same cycle
//   rnd_state, rnd_key   state register and current round key fed to both datapaths
//   rnd_out, fin_out     full-round and final-round (no MixColumns) datapath results
//   out_valid/out_ready  ciphertext handshake, out_data = state register
//   busy                 high while rounds are being applied (ROUND or FINAL)
//   abort                only when AES_ROUND_CTRL_ABORT_EN is defined: drops the block in flight
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = NR_FOR_NK(Nk)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [AES_BLOCK_W-1:0]  in_data,
    output logic [RK_IDX_W-1:0]     rk_idx,
    input  logic [AES_BLOCK_W-1:0]  rk_data,
    output logic [AES_BLOCK_W-1:0]  rnd_state,
    output logic [AES_BLOCK_W-1:0]  rnd_key,
    input  logic [AES_BLOCK_W-1:0]  rnd_out,
    input  logic [AES_BLOCK_W-1:0]  fin_out,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [AES_BLOCK_W-1:0]  out_data,
    output logic                    busy
);

    localparam logic [RK_IDX_W-1:0] NR_IDX  = RK_IDX_W'(Nr);
    localparam logic [RK_IDX_W-1:0] NR_LAST = RK_IDX_W'(Nr - 1);

    aes_state_e              state_q, state_d;
    logic [RK_IDX_W-1:0]     cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0]  blk_q, blk_d;
    logic                    abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    // rk_idx and all handshake outputs decode from registered state only,
    // so the key store address never depends on in_valid/out_ready.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        blk_d     = blk_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        rk_idx    = '0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Initial AddRoundKey uses key 0, which is on rk_data right now.
                    blk_d   = in_data ^ rk_data;
                    cnt_d   = RK_IDX_W'(1);
                    state_d = (Nr == 1) ? ST_FINAL : ST_ROUND;
                end
            end
            ST_ROUND: begin
                busy    = 1'b1;
                rk_idx  = cnt_q;
                blk_d   = rnd_out;
                // Stops at Nr: the last ROUND cycle has cnt == Nr-1.
                cnt_d   = cnt_q + RK_IDX_W'(1);
                if (cnt_q == NR_LAST) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                busy    = 1'b1;
                rk_idx  = NR_IDX;
                blk_d   = fin_out;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort only matters while rounds are in flight; the partial block is dropped.
        if (abort_hit && (state_q == ST_ROUND || state_q == ST_FINAL)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            blk_d   = blk_q;
        end
    end

    assign rnd_state = blk_q;
    assign rnd_key   = rk_data;
    assign out_data  = blk_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (Nr=10 with a 128-bit key, Nr=14 with a 256-bit key),
// behavioural AES datapaths and key stores, a time-since-accept scoreboard checked every cycle,
// and directed FIPS-197 vectors plus back-pressure, mid-block reset and (optionally) abort.
module tb_aes_round_ctrl;

    localparam int NR_A = 10;
    localparam int NR_B = 14;
    localparam logic [255:0] KEY_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT3 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- AES reference functions ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: inverse in GF(2^8) (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, sq, v;
        r = 8'h01; sq = x;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        v = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]};
        return v ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round key r of the expansion of a key held left-aligned in 256 bits.
    function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int r);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        if (r < 0 || r > nr) return '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // One AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic full);
        logic [7:0]   b [16];
        logic [7:0]   c [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                c[row+4*col] = b[row + 4*((col + row) % 4)];
        if (full) begin
            for (int col = 0; col < 4; col++) begin
                a0 = c[4*col]; a1 = c[4*col+1]; a2 = c[4*col+2]; a3 = c[4*col+3];
                c[4*col]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
                c[4*col+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
                c[4*col+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
                c[4*col+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = c[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                 input int nk);
        logic [127:0] s;
        s = pt ^ round_key(key, nk, 0);
        for (int r = 1; r < nk + 6; r++) s = aes_round(s, round_key(key, nk, r), 1'b1);
        return aes_round(s, round_key(key, nk, nk + 6), 1'b0);
    endfunction

    // ---------------- DUT A (Nr=10) ----------------
    logic         rst_a = 1'b1, in_valid_a = 1'b0, out_ready_a = 1'b0;
    logic [127:0] in_data_a = '0;
    logic         in_ready_a, out_valid_a, busy_a;
    logic [3:0]   rk_idx_a;
    logic [127:0] rk_data_a, rnd_state_a, rnd_key_a, rnd_out_a, fin_out_a, out_data_a;

    // ---------------- DUT B (Nr=14) ----------------
    logic         rst_b = 1'b1, in_valid_b = 1'b0, out_ready_b = 1'b0;
    logic [127:0] in_data_b = '0;
    logic         in_ready_b, out_valid_b, busy_b;
    logic [3:0]   rk_idx_b;
    logic [127:0] rk_data_b, rnd_state_b, rnd_key_b, rnd_out_b, fin_out_b, out_data_b;

`ifdef AES_ROUND_CTRL_ABORT_EN
    logic abort_a = 1'b0;
    logic abort_b = 1'b0;
    wire  ab_a = abort_a;
    wire  ab_b = abort_b;
`else
    wire  ab_a = 1'b0;
    wire  ab_b = 1'b0;
`endif

    assign rk_data_a = round_key(KEY_A, 4, int'(rk_idx_a));
    assign rnd_out_a = aes_round(rnd_state_a, rnd_key_a, 1'b1);
    assign fin_out_a = aes_round(rnd_state_a, rnd_key_a, 1'b0);
    assign rk_data_b = round_key(KEY_B, 8, int'(rk_idx_b));
    assign rnd_out_b = aes_round(rnd_state_b, rnd_key_b, 1'b1);
    assign fin_out_b = aes_round(rnd_state_b, rnd_key_b, 1'b0);

    aes_round_ctrl #(.Nk(4), .Nr(NR_A)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .rk_idx(rk_idx_a), .rk_data(rk_data_a),
        .rnd_state(rnd_state_a), .rnd_key(rnd_key_a), .rnd_out(rnd_out_a), .fin_out(fin_out_a),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort(abort_a),
`endif
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .busy(busy_a)
    );

    aes_round_ctrl #(.Nk(8), .Nr(NR_B)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .rk_idx(rk_idx_b), .rk_data(rk_data_b),
        .rnd_state(rnd_state_b), .rnd_key(rnd_key_b), .rnd_out(rnd_out_b), .fin_out(fin_out_b),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort(abort_b),
`endif
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
    );

    // ---------------- check helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // t = cycles since the block was accepted: 0 = idle/ready, 1..nr = rounds being
    // applied (key t fetched), nr+1 = ciphertext waiting for the consumer.
    int           t_a = 0, t_b = 0;
    logic [127:0] ct_a = '0, ct_b = '0;
    bit           chk_en = 1'b0;

    task automatic cmp_inst(input string tag, input int nr, input int nk, input logic [255:0] key,
                            input int t, input logic [127:0] ct,
                            input logic irdy, input logic ovld, input logic bsy,
                            input logic [3:0] idx, input logic [127:0] rkey,
                            input logic [127:0] odat);
        int exp_idx;
        exp_idx = (t >= 1 && t <= nr) ? t : 0;
        chk1({tag, " in_ready"}, irdy, t == 0);
        chk1({tag, " out_valid"}, ovld, t == nr + 1);
        chk1({tag, " busy"}, bsy, t >= 1 && t <= nr);
        chkn({tag, " rk_idx"}, int'(idx), exp_idx);
        chk128({tag, " rnd_key"}, rkey, round_key(key, nk, exp_idx));
        if (t == nr + 1) chk128({tag, " out_data"}, odat, ct);
    endtask

    task automatic step_inst(input int nr, input int nk, input logic [255:0] key,
                             input logic rst_i, input logic iv, input logic [127:0] din,
                             input logic ordy, input logic abrt,
                             input int t_in, input logic [127:0] ct_in,
                             output int t_out, output logic [127:0] ct_out);
        t_out  = t_in;
        ct_out = ct_in;
        if (rst_i) begin
            t_out = 0;
        end else if (t_in == 0) begin
            if (iv) begin
                t_out  = 1;
                ct_out = aes_encrypt(din, key, nk);
            end
        end else if (t_in <= nr) begin
            t_out = abrt ? 0 : t_in + 1;
        end else if (ordy) begin
            t_out = 0;
        end
    endtask

    // Inputs change only just after posedge, so what is seen here is what the DUT
    // sees at the next edge.
    always @(negedge clk) begin
        int           nt_a, nt_b;
        logic [127:0] nc_a, nc_b;
        if (chk_en) begin
            cmp_inst("A", NR_A, 4, KEY_A, t_a, ct_a, in_ready_a, out_valid_a, busy_a,
                     rk_idx_a, rnd_key_a, out_data_a);
            cmp_inst("B", NR_B, 8, KEY_B, t_b, ct_b, in_ready_b, out_valid_b, busy_b,
                     rk_idx_b, rnd_key_b, out_data_b);
        end
        step_inst(NR_A, 4, KEY_A, rst_a, in_valid_a, in_data_a, out_ready_a, ab_a,
                  t_a, ct_a, nt_a, nc_a);
        step_inst(NR_B, 8, KEY_B, rst_b, in_valid_b, in_data_b, out_ready_b, ab_b,
                  t_b, ct_b, nt_b, nc_b);
        t_a  <= nt_a;
        ct_a <= nc_a;
        t_b  <= nt_b;
        ct_b <= nc_b;
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle right after acceptance; returns in the first out_valid cycle.
    task automatic wait_a(output int lat);
        lat = 1;
        while (!out_valid_a && lat < 40) begin
            tick();
            lat++;
        end
        chk1("wait_a out_valid", out_valid_a, 1'b1);
    endtask

    initial begin
        int           trace [$];
        int           lat;
        logic [127:0] exp2, exp3;

        exp2 = aes_encrypt(PT2, KEY_A, 4);
        exp3 = aes_encrypt(PT3, KEY_A, 4);

        repeat (3) @(posedge clk);
        #1;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        chk_en = 1'b1;

        // Pin the reference model to published values.
        chkn("sbox_00", int'(sbox(8'h00)), 'h63);
        chkn("sbox_01", int'(sbox(8'h01)), 'h7c);
        chkn("sbox_53", int'(sbox(8'h53)), 'hed);
        chk128("model_rk1", round_key(KEY_A, 4, 1), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        chk128("model_c1", aes_encrypt(PT1, KEY_A, 4), CT1);
        chk128("model_c3", aes_encrypt(PT1, KEY_B, 8), CT3);

        // Reset values.
        chk1("rst in_ready", in_ready_a, 1'b1);
        chk1("rst out_valid", out_valid_a, 1'b0);
        chk1("rst busy", busy_a, 1'b0);
        chkn("rst rk_idx", int'(rk_idx_a), 0);
        chk128("rst state", rnd_state_a, 128'h0);

        // FIPS-197 C.1: exact latency and key-index trace.
        out_ready_a = 1'b1;
        in_data_a   = PT1;
        in_valid_a  = 1'b1;
        #1;
        trace.push_back(int'(rk_idx_a));
        chk1("c1 accept in_ready", in_ready_a, 1'b1);
        tick();
        in_valid_a = 1'b0;
        for (int k = 1; k <= NR_A; k++) begin
            trace.push_back(int'(rk_idx_a));
            chk1("c1 in_ready low", in_ready_a, 1'b0);
            chk1("c1 out_valid early", out_valid_a, 1'b0);
            tick();
        end
        chk1("c1 out_valid", out_valid_a, 1'b1);
        chk128("c1 ciphertext", out_data_a, CT1);
        for (int k = 0; k <= NR_A; k++) chkn("c1 rk_idx trace", trace[k], k);
        tick();
        chk1("c1 back idle", in_ready_a, 1'b1);

        // Back-pressure: DONE holds while out_ready is low, extra in_valid ignored.
        out_ready_a = 1'b0;
        in_data_a   = PT2;
        in_valid_a  = 1'b1;
        tick();
        in_valid_a = 1'b0;
        wait_a(lat);
        chkn("bp latency", lat, NR_A + 1);
        in_data_a  = PT3;
        in_valid_a = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk1("bp out_valid", out_valid_a, 1'b1);
            chk128("bp out_data", out_data_a, exp2);
            chk1("bp in_ready", in_ready_a, 1'b0);
            tick();
        end
        out_ready_a = 1'b1;
        tick();
        chk1("bp release out_valid", out_valid_a, 1'b0);
        chk1("bp release in_ready", in_ready_a, 1'b1);
        tick();
        in_valid_a = 1'b0;
        chk1("bp next accepted", busy_a, 1'b1);
        wait_a(lat);
        chk128("bp next ciphertext", out_data_a, exp3);
        tick();

        // Reset in the middle of round 5: block dropped, no output.
        in_data_a  = PT1;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (4) tick();
        chkn("mid rk_idx round5", int'(rk_idx_a), 5);
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk1("mid rst out_valid", out_valid_a, 1'b0);
        chk1("mid rst in_ready", in_ready_a, 1'b1);
        chk1("mid rst busy", busy_a, 1'b0);
        for (int k = 0; k < 15; k++) begin
            chk1("mid rst no output", out_valid_a, 1'b0);
            tick();
        end
        in_data_a  = PT2;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        wait_a(lat);
        chkn("mid rst next latency", lat, NR_A + 1);
        chk128("mid rst next ciphertext", out_data_a, exp2);
        tick();

`ifdef AES_ROUND_CTRL_ABORT_EN
        // Abort at round 3, then an immediate new block.
        in_data_a  = PT1;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (2) tick();
        chkn("abort rk_idx round3", int'(rk_idx_a), 3);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk1("abort in_ready", in_ready_a, 1'b1);
        chk1("abort out_valid", out_valid_a, 1'b0);
        chk1("abort busy", busy_a, 1'b0);
        in_data_a  = PT3;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        wait_a(lat);
        chkn("abort next latency", lat, NR_A + 1);
        chk128("abort next ciphertext", out_data_a, exp3);
        tick();
`endif

        // FIPS-197 C.3 on the Nr=14 instance.
        out_ready_b = 1'b1;
        in_data_b   = PT1;
        in_valid_b  = 1'b1;
        tick();
        in_valid_b = 1'b0;
        lat = 1;
        while (!out_valid_b && lat < 40) begin
            tick();
            lat++;
        end
        chk1("c3 out_valid", out_valid_b, 1'b1);
        chkn("c3 latency", lat, NR_B + 1);
        chk128("c3 ciphertext", out_data_b, CT3);
        tick();
        chk1("c3 back idle", in_ready_b, 1'b1);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
